ibm_mc: RTL and testbench

// Parametrised ingress buffer manager; successor to the fixed 134-bit single-mode ingress block.

---
 rtl/ibm_mc.sv | 144 ++++++++++++++
 tb/tb_ibm_mc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibm_mc.sv
// ibm_mc: ingress buffer manager that filters packets by type and free buffers, truncates oversize
// packets, forwards flits with one-cycle latency and emits delayed per-packet metadata plus statistics.
module ibm_mc #(
  parameter int DW        = 134,
  parameter int TYPE_LSB  = 80,
  parameter int TYPE_MAX  = 4,
  parameter int MDW       = 24,
  parameter int IDW       = 8,
  parameter int FCW       = 5,
  parameter int MAX_FLITS = 128,
  parameter int MD_DLY    = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    in_data,
  input  logic             in_data_wr,
  input  logic             in_valid,
  input  logic [MDW-1:0]   in_tsn_md,
  input  logic             in_tsn_md_wr,
  input  logic [IDW-1:0]   in_buf_id,
  input  logic [FCW-1:0]   in_buf_free,
  output logic [FCW-1:0]   out_bufm_free,
  input  logic             cfg_drop_all,
  input  logic             stat_clr,
  output logic [DW-1:0]    out_data,
  output logic             out_data_wr,
  output logic             out_valid,
  output logic             out_valid_wr,
  output logic [MDW-1:0]   out_md,
  output logic             out_md_wr,
  output logic [CNT_W-1:0] stat_fwd,
  output logic [CNT_W-1:0] stat_drop,
  output logic [CNT_W-1:0] stat_trunc
);
  localparam int CW = $clog2(MAX_FLITS) + 1;
  typedef enum logic [1:0] {IDLE, TRANS, DISC} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [MDW-1:0] r_md_sh, r_md_pkt, w_md;
  logic [7:0] w_type, w_id;
  logic [DW-1:0] w_odata;
  logic w_head, w_tail, w_accept, w_fwd, w_force_tail, w_vwr, w_valid;
  logic w_inc_fwd, w_inc_drop, w_inc_trunc, w_latch;
  logic [MD_DLY-1:0] r_dv;
  logic [MDW-1:0] r_dm [MD_DLY];
  logic [DW-1:0] r_out_data;
  logic [MDW-1:0] r_out_md;
  logic r_out_data_wr, r_out_valid, r_out_valid_wr, r_out_md_wr;
  logic [CNT_W-1:0] r_fwd, r_drop, r_trunc;
  assign w_head = in_data_wr && in_data[DW-1:DW-2] == 2'b01;
  assign w_tail = in_data_wr && in_data[DW-1:DW-2] == 2'b10;
  assign w_type = in_data[TYPE_LSB +: 8];
  assign w_accept = (w_type == 8'd1 || w_type > 8'(TYPE_MAX)) && in_buf_free != '0 && !cfg_drop_all;
  assign w_md = in_tsn_md_wr ? in_tsn_md : r_md_sh;
  assign w_id = 8'(in_buf_id);
  assign w_odata = w_force_tail ? {2'b10, in_data[DW-3:0]} : in_data;
  assign out_bufm_free = in_buf_free;
  assign out_data = r_out_data;
  assign out_data_wr = r_out_data_wr;
  assign out_valid = r_out_valid;
  assign out_valid_wr = r_out_valid_wr;
  assign out_md = r_out_md;
  assign out_md_wr = r_out_md_wr;
  assign stat_fwd = r_fwd;
  assign stat_drop = r_drop;
  assign stat_trunc = r_trunc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    w_fwd = 1'b0;
    w_force_tail = 1'b0;
    w_vwr = 1'b0;
    w_valid = 1'b0;
    w_inc_fwd = 1'b0;
    w_inc_drop = 1'b0;
    w_inc_trunc = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      IDLE: if (w_head) begin
        w_fwd = w_accept;
        w_latch = w_accept;
        w_inc_drop = !w_accept;
        w_state_nxt = w_accept ? TRANS : DISC;
      end
      TRANS: if (in_data_wr) begin
        w_fwd = 1'b1;
        if (w_tail) begin
          w_vwr = 1'b1;
          w_valid = in_valid;
          w_inc_fwd = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CW'(MAX_FLITS - 1)) begin
          w_force_tail = 1'b1;
          w_vwr = 1'b1;
          w_inc_fwd = 1'b1;
          w_inc_trunc = 1'b1;
          w_state_nxt = DISC;
        end
      end
      DISC: w_state_nxt = w_tail ? IDLE : DISC;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_md_sh <= '0;
      r_md_pkt <= '0;
      r_out_data <= '0;
      r_out_data_wr <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_valid_wr <= 1'b0;
      r_out_md <= '0;
      r_out_md_wr <= 1'b0;
      r_dv <= '0;
      for (int i = 0; i < MD_DLY; i++) r_dm[i] <= '0;
      r_fwd <= '0;
      r_drop <= '0;
      r_trunc <= '0;
    end else begin
      r_cnt <= w_latch ? CW'(1) : w_fwd ? r_cnt + CW'(1) : r_cnt;
      r_md_sh <= in_tsn_md_wr ? in_tsn_md : r_md_sh;
      r_md_pkt <= w_latch ? {w_md[MDW-1:8], w_id} : r_md_pkt;
      r_out_data <= w_fwd ? w_odata : r_out_data;
      r_out_data_wr <= w_fwd;
      r_out_valid <= w_valid;
      r_out_valid_wr <= w_vwr;
      // each good tail enters its own delay slot so back-to-back packets never collide
      r_dv[0] <= w_vwr & w_valid;
      r_dm[0] <= r_md_pkt;
      for (int i = 1; i < MD_DLY; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_dm[i] <= r_dm[i-1];
      end
      r_out_md_wr <= r_dv[MD_DLY-1];
      r_out_md <= r_dv[MD_DLY-1] ? r_dm[MD_DLY-1] : r_out_md;
      r_fwd <= (stat_clr ? '0 : r_fwd) + CNT_W'(w_inc_fwd);
      r_drop <= (stat_clr ? '0 : r_drop) + CNT_W'(w_inc_drop);
      r_trunc <= (stat_clr ? '0 : r_trunc) + CNT_W'(w_inc_trunc);
    end
endmodule

// File: tb/tb_ibm_mc.sv
// tb_ibm_mc: randomized packet-level scoreboard bench for ibm_mc; expected flits, valid pulses and
// metadata are queued at stimulus time and popped by an independent output monitor.
module tb_ibm_mc;
  localparam int DW = 134, TL = 80, TM = 4, MDW = 24, IDW = 8, FCW = 5, MF = 4, MD = 2, CW = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [DW-1:0] in_data;
  logic in_data_wr, in_valid, in_tsn_md_wr, cfg_drop_all, stat_clr;
  logic [MDW-1:0] in_tsn_md;
  logic [IDW-1:0] in_buf_id;
  logic [FCW-1:0] in_buf_free, out_bufm_free;
  logic [DW-1:0] out_data;
  logic out_data_wr, out_valid, out_valid_wr, out_md_wr;
  logic [MDW-1:0] out_md;
  logic [CW-1:0] stat_fwd, stat_drop, stat_trunc;
  ibm_mc #(.DW(DW), .TYPE_LSB(TL), .TYPE_MAX(TM), .MDW(MDW), .IDW(IDW), .FCW(FCW),
           .MAX_FLITS(MF), .MD_DLY(MD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_data_wr(in_data_wr), .in_valid(in_valid),
    .in_tsn_md(in_tsn_md), .in_tsn_md_wr(in_tsn_md_wr), .in_buf_id(in_buf_id),
    .in_buf_free(in_buf_free), .out_bufm_free(out_bufm_free), .cfg_drop_all(cfg_drop_all),
    .stat_clr(stat_clr), .out_data(out_data), .out_data_wr(out_data_wr), .out_valid(out_valid),
    .out_valid_wr(out_valid_wr), .out_md(out_md), .out_md_wr(out_md_wr), .stat_fwd(stat_fwd),
    .stat_drop(stat_drop), .stat_trunc(stat_trunc));
  typedef struct {logic [DW-1:0] d; int c;} fl_t;
  typedef struct {logic v; int c;} vl_t;
  typedef struct {logic [MDW-1:0] m; int c;} md_t;
  fl_t fq[$];
  vl_t vq[$];
  md_t mq[$];
  fl_t f;
  vl_t v;
  md_t m;
  int cyc = 0;
  int n_assert = 0, n_fail = 0;
  logic [MDW-1:0] sh;
  int unsigned m_fwd, m_drop, m_trunc;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic unexp(input string nm);
    n_assert++;
    n_fail++;
    $display("FAIL %s: output pulse with nothing expected (cycle %0d)", nm, cyc);
  endtask
  function automatic logic [DW-1:0] rnd();
    logic [159:0] t;
    for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction
  always @(negedge clk) if (rst_n) begin
    chk("bufm_free", DW'(out_bufm_free), DW'(in_buf_free));
    if (out_data_wr) begin
      if (fq.size() == 0) unexp("flit");
      else begin
        f = fq.pop_front();
        chk("flit_data", out_data, f.d);
        chk("flit_cycle", DW'(cyc), DW'(f.c));
      end
    end
    if (out_valid_wr) begin
      if (vq.size() == 0) unexp("valid_wr");
      else begin
        v = vq.pop_front();
        chk("out_valid", DW'(out_valid), DW'(v.v));
        chk("valid_cycle", DW'(cyc), DW'(v.c));
      end
    end
    if (out_md_wr) begin
      if (mq.size() == 0) unexp("md_wr");
      else begin
        m = mq.pop_front();
        chk("out_md", DW'(out_md), DW'(m.m));
        chk("md_cycle", DW'(cyc), DW'(m.c));
      end
    end
  end
  task automatic step();
    if (in_tsn_md_wr) sh = in_tsn_md;
    @(posedge clk);
    #1;
    in_data_wr = 1'b0;
    in_data = rnd();
    in_valid = 1'($urandom);
    in_tsn_md_wr = ($urandom_range(0, 4) == 0);
    in_tsn_md = MDW'($urandom);
    in_buf_id = IDW'($urandom);
    in_buf_free = FCW'($urandom);
    cfg_drop_all = 1'($urandom);
    stat_clr = 1'b0;
  endtask
  task automatic send_pkt(input int typ, input int n, input bit good, input int free, input bit drop,
                          input int gapmax, input bit clr, input bit mdf, input logic [MDW-1:0] md,
                          input logic [IDW-1:0] id);
    logic [DW-1:0] d, e;
    logic [MDW-1:0] mu, pmd;
    bit acc, trunc;
    int nout;
    acc = 1'b0;
    pmd = '0;
    trunc = n > MF;
    nout = trunc ? MF : n;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapmax)) step();
      d = rnd();
      d[DW-1:DW-2] = i == 0 ? 2'b01 : i == n - 1 ? 2'b10 : ($urandom_range(0, 5) == 0 ? 2'b01 : 2'b11);
      if (i == 0) begin
        d[TL +: 8] = 8'(typ);
        in_buf_free = FCW'(free);
        cfg_drop_all = drop;
        stat_clr = clr;
        if (mdf) begin
          in_tsn_md_wr = 1'b1;
          in_tsn_md = md;
          in_buf_id = id;
        end
        mu = in_tsn_md_wr ? in_tsn_md : sh;
        pmd = {mu[MDW-1:8], in_buf_id};
        acc = (typ == 1 || typ > TM) && free != 0 && !drop;
        if (clr) begin
          m_fwd = 0;
          m_drop = 0;
          m_trunc = 0;
        end
        if (!acc) m_drop++;
      end
      if (i == n - 1) in_valid = good;
      in_data = d;
      in_data_wr = 1'b1;
      if (acc && i < nout) begin
        e = d;
        if (trunc && i == nout - 1) e[DW-1:DW-2] = 2'b10;
        fq.push_back('{e, cyc + 1});
        if (i == nout - 1) begin
          vq.push_back('{(trunc ? 1'b0 : good), cyc + 1});
          m_fwd++;
          if (trunc) m_trunc++;
          if (good && !trunc) mq.push_back('{pmd, cyc + 1 + MD});
        end
      end
      step();
    end
  endtask
  task automatic drain();
    repeat (MD + 4) step();
  endtask
  task automatic chk_stats();
    repeat (2) step();
    chk("stat_fwd", DW'(stat_fwd), DW'(m_fwd));
    chk("stat_drop", DW'(stat_drop), DW'(m_drop));
    chk("stat_trunc", DW'(stat_trunc), DW'(m_trunc));
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_data"}, out_data, '0);
    chk({nm, "_data_wr"}, DW'(out_data_wr), '0);
    chk({nm, "_valid"}, DW'(out_valid), '0);
    chk({nm, "_valid_wr"}, DW'(out_valid_wr), '0);
    chk({nm, "_md"}, DW'(out_md), '0);
    chk({nm, "_md_wr"}, DW'(out_md_wr), '0);
    chk({nm, "_fwd"}, DW'(stat_fwd), '0);
    chk({nm, "_drop"}, DW'(stat_drop), '0);
    chk({nm, "_trunc"}, DW'(stat_trunc), '0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [DW-1:0] d;
    rst_n = 1'b0;
    in_data = '0;
    in_data_wr = 1'b0;
    in_valid = 1'b0;
    in_tsn_md = '0;
    in_tsn_md_wr = 1'b0;
    in_buf_id = '0;
    in_buf_free = '0;
    cfg_drop_all = 1'b0;
    stat_clr = 1'b0;
    sh = '0;
    m_fwd = 0;
    m_drop = 0;
    m_trunc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    send_pkt(1, 5, 1, 3, 0, 0, 0, 0, '0, '0);
    chk_stats();
    send_pkt(3, 4, 1, 3, 0, 1, 0, 0, '0, '0);
    send_pkt(5, 4, 1, 3, 0, 1, 0, 0, '0, '0);
    chk_stats();
    send_pkt(6, 3, 1, 0, 0, 0, 0, 0, '0, '0);
    send_pkt(6, 3, 1, 1, 0, 0, 0, 0, '0, '0);
    chk_stats();
    send_pkt(1, 7, 1, 2, 0, 0, 0, 0, '0, '0);
    chk_stats();
    send_pkt(1, 3, 0, 2, 0, 0, 0, 1, 24'hABCD12, 8'h07);
    send_pkt(9, 3, 1, 2, 0, 0, 0, 1, 24'hABCD12, 8'h07);
    send_pkt(1, 2, 1, 1, 0, 0, 0, 0, '0, '0);
    send_pkt(7, 2, 1, 1, 0, 0, 0, 0, '0, '0);
    send_pkt(1, 3, 1, 1, 1, 0, 0, 0, '0, '0);
    chk_stats();
    drain();
    send_pkt(2, 2, 1, 1, 0, 0, 1, 0, '0, '0);
    chk_stats();
    drain();
    d = rnd();
    d[DW-1:DW-2] = 2'b01;
    d[TL +: 8] = 8'd1;
    in_data = d;
    in_data_wr = 1'b1;
    in_buf_free = 1;
    cfg_drop_all = 1'b0;
    fq.push_back('{d, cyc + 1});
    step();
    d = rnd();
    d[DW-1:DW-2] = 2'b11;
    in_data = d;
    in_data_wr = 1'b1;
    fq.push_back('{d, cyc + 1});
    step();
    step();
    rst_n = 1'b0;
    sh = '0;
    m_fwd = 0;
    m_drop = 0;
    m_trunc = 0;
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d = rnd();
    d[DW-1:DW-2] = 2'b11;
    in_data = d;
    in_data_wr = 1'b1;
    step();
    d = rnd();
    d[DW-1:DW-2] = 2'b10;
    in_data = d;
    in_data_wr = 1'b1;
    step();
    send_pkt(200, 3, 1, 1, 0, 0, 0, 0, '0, '0);
    chk_stats();
    for (int p = 0; p < 300; p++) begin
      int typ;
      if (p == 150) begin
        drain();
        stat_clr = 1'b1;
        m_fwd = 0;
        m_drop = 0;
        m_trunc = 0;
        step();
      end
      typ = $urandom_range(0, 9);
      if (typ == 9) typ = 255;
      send_pkt(typ, $urandom_range(2, 7), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 9) == 0,
               $urandom_range(0, 2), 0, 1'($urandom), MDW'($urandom), IDW'($urandom));
    end
    drain();
    chk_stats();
    chk("flit_q_left", DW'(fq.size()), '0);
    chk("valid_q_left", DW'(vq.size()), '0);
    chk("md_q_left", DW'(mq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
